// File: rtl/spi_ram_slave_param_pkg.sv
// Shared opcodes, FSM state type and counter sizing for the parametrised SPI RAM slave.
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_FETCH,
        RD_DATA,
        HOLD
    } state_t;

    // Bit counter must index the longer of the address and data fields.
    function automatic int cnt_w(input int addr_w, input int data_w);
        int m;
        m = (addr_w > data_w) ? addr_w : data_w;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/spi_ram_slave_param_mem.sv
// Single-port RAM: synchronous write, registered read, one access per cycle.
module spi_ram_sp_mem #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_slave_param.sv
// SPI slave fronting a single-port RAM; address/data widths generic.
// Define SPI_RAM_BURST_EN for auto-increment burst writes and back-to-back burst reads.
module spi_ram_slave_param #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic frame_err
);
    import spi_ram_pkg::*;

`ifdef SPI_RAM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam int SW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CW = cnt_w(ADDR_W, DATA_W);
    localparam logic [CW-1:0]     ADDR_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0]     DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0]     OP_LAST   = CW'(1);
    localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(MEM_DEPTH - 1);

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
        return ADDR_W'(32'(a) % MEM_DEPTH);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_TOP) ? '0 : a + 1'b1;
    endfunction

    state_t            state;
    logic [CW-1:0]     bit_cnt;
    logic [SW-2:0]     shift;
    logic [ADDR_W-1:0] wr_addr, rd_addr, mem_addr, field_addr;
    logic [DATA_W-1:0] field_word, rd_word;
    logic [CW-1:0]     rd_idx;
    logic              mem_we, mem_re, abort;

    // The shift register holds only the bits before the current one; mosi completes the field.
    assign field_addr = {shift[ADDR_W-2:0], mosi};
    assign field_word = {shift[DATA_W-2:0], mosi};
    assign rd_idx     = DATA_LAST - bit_cnt;

    assign mem_we = !ss_n && (state == WR_DATA) && (bit_cnt == DATA_LAST);
    assign mem_re = !ss_n && ((state == RD_FETCH) ||
                              (BURST && (state == RD_DATA) && (bit_cnt == DATA_LAST)));

    always_comb begin
        mem_addr = rd_addr;
        if (state == WR_DATA) begin
            mem_addr = wr_addr;
        end else if (state == RD_DATA) begin
            mem_addr = next_addr(rd_addr);
        end
    end

    assign abort = (state == CMD) ||
                   (((state == WR_ADDR) || (state == RD_ADDR) ||
                     (state == WR_DATA) || (state == RD_DATA)) && (bit_cnt != '0));

    spi_ram_sp_mem #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (field_word),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            miso      <= 1'b0;
            frame_err <= 1'b0;
        end else if (ss_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            miso      <= 1'b0;
            frame_err <= abort;
        end else begin
            frame_err <= 1'b0;
            miso      <= 1'b0;
            case (state)
                IDLE: begin
                    state   <= CMD;
                    bit_cnt <= '0;
                end
                CMD: begin
                    if (bit_cnt == OP_LAST) begin
                        bit_cnt <= '0;
                        shift   <= '0;
                        case ({shift[0], mosi})
                            OP_WR_ADDR: state <= WR_ADDR;
                            OP_WR_DATA: state <= WR_DATA;
                            OP_RD_ADDR: state <= RD_ADDR;
                            OP_RD_DATA: state <= RD_FETCH;
                            default:    state <= HOLD;
                        endcase
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shift   <= {shift[SW-3:0], mosi};
                    end
                end
                WR_ADDR, RD_ADDR: begin
                    if (bit_cnt == ADDR_LAST) begin
                        if (state == WR_ADDR) wr_addr <= wrap_addr(field_addr);
                        else                  rd_addr <= wrap_addr(field_addr);
                        bit_cnt <= '0;
                        shift   <= '0;
                        state   <= HOLD;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shift   <= {shift[SW-3:0], mosi};
                    end
                end
                WR_DATA: begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        shift   <= '0;
                        if (BURST) wr_addr <= next_addr(wr_addr);
                        else       state   <= HOLD;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shift   <= {shift[SW-3:0], mosi};
                    end
                end
                RD_FETCH: begin
                    bit_cnt <= '0;
                    state   <= RD_DATA;
                end
                RD_DATA: begin
                    miso <= rd_word[rd_idx];
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        if (BURST) rd_addr <= next_addr(rd_addr);
                        else       state   <= HOLD;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_ram_slave_param.md
Name: spi_ram_slave_param

Overview:
Parametrised SPI slave with an embedded single-port RAM. It is the next generation of the fixed 8-bit SPI/RAM slave.
- Address and data widths are generic.
- Adds a frame-abort error flag.
- Adds an optional auto-increment burst mode.
- Sits at chip top as the host-visible register/memory window. Single clock domain; SPI bit clock equals clk.

Parameters:
ADDR_W, 8, RAM address width in bits
DATA_W, 8, RAM word width in bits
MEM_DEPTH, 256, number of RAM words; must be <= 2**ADDR_W; address wraps at MEM_DEPTH-1

Ports:
clk  input  1  system clock; all sampling on rising edge
rst_n  input  1  asynchronous active-low reset
ss_n  input  1  slave select, active low; frames a transaction
mosi  input  1  serial data in, MSB first
miso  output  1  serial data out, MSB first
frame_err  output  1  one-cycle pulse when a frame ends mid-field

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; miso=0; frame_err=0.
  - wr_addr=0, rd_addr=0, shift register cleared.
  - RAM contents not reset.
- States: IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_FETCH, RD_DATA, HOLD.
- IDLE: first rising edge with ss_n=0 moves to CMD. No bit is sampled on this turnaround edge.
- CMD: samples 2 opcode bits on 2 consecutive edges, MSB first.
  - 00 -> WR_ADDR
  - 01 -> WR_DATA
  - 10 -> RD_ADDR
  - 11 -> RD_FETCH
- WR_ADDR / RD_ADDR:
  - Shift ADDR_W bits.
  - On the edge sampling the last bit, load wr_addr/rd_addr (truncated modulo MEM_DEPTH); go to HOLD.
- WR_DATA: shift DATA_W bits; on the edge sampling the last bit, mem[wr_addr] <= word.
  - Without burst: go to HOLD.
  - With burst: see Optional Feature.
- RD_FETCH:
  - One cycle; registered RAM read, rd_word <= mem[rd_addr]; go to RD_DATA.
  - Read latency: first data bit on miso 2 edges after the last opcode bit is sampled.
- RD_DATA:
  - miso presents rd_word bits MSB first, one per clock, updated on the rising edge.
  - mosi ignored.
  - After DATA_W bits, go to HOLD; miso returns to 0.
- HOLD: all mosi ignored until ss_n=1.
- ss_n=1 at any edge:
  - state -> IDLE; partial shift discarded; no RAM write; miso=0.
  - wr_addr/rd_addr retained.
- frame_err:
  - Pulses 1 cycle when ss_n rises while in CMD, in a WR/RD_ADDR/WR_DATA field with 1..N-1 bits shifted, or mid-word in RD_DATA.
  - No pulse from IDLE, HOLD, or at a word boundary.
- RD_DATA before any RD_ADDR reads address 0.
- Reads and writes never overlap: one operation per frame, single RAM port.
- rst_n assertion mid-frame aborts immediately. No RAM write; frame_err stays 0.

Optional Feature:
Macro SPI_RAM_BURST_EN.
- Defined:
  - WR_DATA stays in WR_DATA after each word. wr_addr increments (MEM_DEPTH-1 -> 0) and the next DATA_W bits write the next word.
  - RD_DATA prefetches mem[rd_addr+1] during the last bit of the current word. Words stream back-to-back with no gap; rd_addr increments per word and wraps.
  - Frame continues until ss_n=1.
- Not defined: one word per frame, then HOLD; addresses never auto-increment.

Decomposition:
- Package spi_ram_pkg:
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11
  - state enum type
  - bit-counter width function clog2(max(ADDR_W,DATA_W))
- Sub-module spi_ram_sp_mem: single-port RAM, synchronous write, registered read, parametrised by ADDR_W/DATA_W/MEM_DEPTH.
  - Instanced as u_mem; array named mem for $readmemb preload from benches.

Test Plan:
1. Reset: assert rst_n=0 after 3 payload bits of WR_DATA -> miso=0, frame_err=0, mem unchanged, next frame decodes normally.
2. Write: frame 00+0x3C, then frame 01+0xA5 -> mem[0x3C]=0xA5 at the last-bit edge; mem[0x3D] unchanged.
3. Read: frame 10+0x3C, then frame 11 -> miso=1,0,1,0,0,1,0,1, starting the 2nd edge after the last opcode bit; miso=0 afterwards.
4. Abort: write-data frame with ss_n high after 4 of 8 bits -> mem unchanged, frame_err high exactly 1 cycle, wr_addr unchanged.
5. Burst write with SPI_RAM_BURST_EN: addr 0xFF, one frame of 01+0x11+0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22. Without the macro -> mem[0x00] unchanged, second byte ignored.
6. Burst read with SPI_RAM_BURST_EN: rd addr 0xFF, 16 bits clocked after 11 -> 0x11 then 0x22 contiguous with no gap cycle, no frame_err at ss_n rise on the word boundary.
